conv_frame_sched: RTL and testbench
===================================

// Module: conv_frame_sched
// PURPOSE
//  Frame-level scheduler for the 3x3 conv engine. Two pixel sources compete for one engine.
//  Arbitration is round-robin per frame. Each frame runs: engine clear, stream IMG_W*IMG_H
//  pixels back-to-back, then collect (IMG_W-2)*(IMG_H-2) results. Tags results with source id.
//  Sits between the image buffers and the conv engine; replaces ad-hoc per-frame engine resets.
// PARAMETERS
//  DW       16  pixel width (signed)
//  OW       33  engine result width (signed)
//  IMG_W    28  frame width, pixels
//  IMG_H    28  frame height, pixels
//  CLR_CYC  2   cycles eng_rst_n held low before each frame (>=1)
//  DRAIN_TO 16  max cycles waited in DRAIN after last pixel before declaring timeout
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous, active-low reset
//  req          in   2       req[i]: source i has a full frame ready to stream
//  grant        out  2       one-hot; grant[i] high from CLEAR entry until DONE exit
//  src_data     in   2*DW    {src1, src0} pixel data
//  src_valid    in   2       per-source pixel valid
//  src_ready    out  2       pixel accepted from source i this cycle (STREAM and grant[i])
//  eng_rst_n    out  1       engine reset, active low, registered
//  eng_pic      out  DW      pixel to engine, registered
//  eng_pic_vld  out  1       pixel valid to engine, registered
//  eng_out_vld  in   1       engine result valid
//  eng_out      in   OW      engine result
//  res_valid    out  1       result valid (registered copy of eng_out_vld while collecting)
//  res_data     out  OW      result data
//  res_src      out  1       source id of current frame
//  res_last     out  1       with res_valid on final expected result
//  frame_done   out  1       1-cycle pulse at end of frame (ok or error)
//  err_underrun out  1       sticky; src_valid low during STREAM; cleared at next CLEAR
//  err_count    out  1       sticky; result count != expected; cleared at next CLEAR
//  busy         out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset values: grant=0, src_ready=0, eng_rst_n=0, eng_pic=0, eng_pic_vld=0, res_*=0,
//   frame_done=0, err_*=0, busy=0. FSM=IDLE. RR pointer: source 0 has priority first.
//  FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
//  IDLE: eng_rst_n=1. If any req, grant the winner and go to CLEAR.
//   RR: the pointer source wins; otherwise the other one. Pointer flips to the non-winner.
//   Both requesting at once: the pointer source wins.
//  CLEAR: eng_rst_n=0 for exactly CLR_CYC cycles. Clear pix_cnt, res_cnt, err_*. Go to STREAM.
//  STREAM: src_ready[g]=1 every cycle. eng_pic<=src_data[g]; eng_pic_vld<=1.
//   The engine needs one pixel per cycle with no gaps.
//   If src_valid[g]=0: set err_underrun, drop eng_pic_vld, go to DONE (abort).
//   The next frame's CLEAR recovers the engine.
//   After pix_cnt reaches IMG_W*IMG_H-1 (784th pixel), go to DRAIN.
//  Collection: any state except IDLE/CLEAR. Each eng_out_vld: res_valid<=1,
//   res_data<=eng_out, res_cnt++.
//   Expected N=(IMG_W-2)*(IMG_H-2)=676. res_last=1 on the N-th result.
//   Results beyond N are not forwarded; they set err_count.
//  DRAIN: eng_pic_vld=0. Go to DONE when res_cnt==N.
//   Also go to DONE when DRAIN_TO cycles elapse; set err_count if res_cnt<N.
//  DONE: frame_done=1 for one cycle, grant=0, go to IDLE. Engine stays idle until next CLEAR.
//  Latency: eng_pic is src_data delayed by 1 cycle. res_data is eng_out delayed by 1 cycle.
//  Widths: pix_cnt 10b, res_cnt 10b, drain timer clog2(DRAIN_TO+1). Counters saturate.
//  req dropping mid-frame is ignored; only src_valid matters once granted.
//  Async reset mid-frame returns all to reset values immediately. eng_rst_n low resets the engine.
// TESTING
//  1 Single frame src0: req=01, 784 ramp pixels -> grant=01, eng_rst_n low 2 cyc, 676 res_valid,
//    res_last on 676th, res_src=0, frame_done once, no err.
//  2 Both req=11 held for 3 frames -> grants 01,10,01; frame_done between; no overlap of grant.
//  3 src_valid drop at pixel 300 -> err_underrun=1, frame_done, no res_last;
//    next frame clean, err cleared.
//  4 Engine model emits only 600 results -> DRAIN timeout after 16 cyc, err_count=1, frame_done.
//  5 Engine model emits 680 results -> 676 forwarded, res_last on 676th, err_count=1.
//  6 rst_n low at pixel 400 -> all outputs reset values next edge-independent; restart frame passes.

Source files
------------

// File: rtl/conv_frame_sched.sv
// conv_frame_sched
//   Frame-level scheduler for the 3x3 convolution engine. Two pixel sources
//   compete for the engine with round-robin arbitration per frame. Each frame
//   clears the engine, streams IMG_W*IMG_H pixels with no gaps, then collects
//   (IMG_W-2)*(IMG_H-2) results. Each result is tagged with the id of the
//   source that owns the current frame.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   req[1:0]      source i has a full frame ready
//   grant[1:0]    one-hot owner of the current frame (CLEAR through DONE)
//   src_data      {src1, src0} signed pixels; src_valid / src_ready per source
//   eng_rst_n     registered engine reset (low during CLEAR)
//   eng_pic, eng_pic_vld    registered pixel stream to the engine
//   eng_out_vld, eng_out    engine results
//   res_valid, res_data, res_src, res_last   forwarded results, 1-cycle latency
//   frame_done    1-cycle pulse at the end of every frame (ok or aborted)
//   err_underrun  sticky: granted source went invalid while streaming
//   err_count     sticky: result count differed from the expected count
//   busy          high in every state except IDLE
module conv_frame_sched #(
    parameter int DW       = 16,
    parameter int OW       = 33,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int CLR_CYC  = 2,
    parameter int DRAIN_TO = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    output logic [1:0]           grant,
    input  logic [2*DW-1:0]      src_data,
    input  logic [1:0]           src_valid,
    output logic [1:0]           src_ready,
    output logic                 eng_rst_n,
    output logic signed [DW-1:0] eng_pic,
    output logic                 eng_pic_vld,
    input  logic                 eng_out_vld,
    input  logic signed [OW-1:0] eng_out,
    output logic                 res_valid,
    output logic signed [OW-1:0] res_data,
    output logic                 res_src,
    output logic                 res_last,
    output logic                 frame_done,
    output logic                 err_underrun,
    output logic                 err_count,
    output logic                 busy
);

    localparam int         TW       = $clog2(DRAIN_TO + 1);
    localparam int         CLRW     = $clog2(CLR_CYC + 1);
    localparam logic [9:0] PIX_LAST = 10'(IMG_W * IMG_H - 1);
    localparam logic [9:0] RES_N    = 10'((IMG_W - 2) * (IMG_H - 2));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic            gsel;       // owner of the current frame
    logic            rr_ptr;     // source with priority at the next arbitration
    logic [CLRW-1:0] clr_cnt;
    logic [9:0]      pix_cnt;
    logic [9:0]      res_cnt;
    logic [TW-1:0]   drain_cnt;

    logic                 win_id;
    logic                 sel_valid;
    logic signed [DW-1:0] sel_pix;
    logic                 collect;
    logic                 res_take;
    logic                 res_extra;
    logic [9:0]           res_cnt_nxt;
    logic                 drain_expired;

    // Saturating counter increment.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    always_comb begin
        // Pointer source wins if requesting, otherwise the other one.
        win_id        = req[rr_ptr] ? rr_ptr : ~rr_ptr;
        sel_valid     = src_valid[gsel];
        sel_pix       = gsel ? $signed(src_data[2*DW-1:DW]) : $signed(src_data[DW-1:0]);
        collect       = (state == S_STREAM) || (state == S_DRAIN) || (state == S_DONE);
        // Results past the expected count are swallowed and flagged.
        res_take      = collect && eng_out_vld && (res_cnt < RES_N);
        res_extra     = collect && eng_out_vld && (res_cnt >= RES_N);
        res_cnt_nxt   = res_take ? sat_inc(res_cnt) : res_cnt;
        drain_expired = (drain_cnt == TW'(DRAIN_TO - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req) state_nxt = S_CLEAR;
            S_CLEAR:  if (clr_cnt == CLRW'(CLR_CYC - 1)) state_nxt = S_STREAM;
            S_STREAM: begin
                if (!sel_valid)              state_nxt = S_DONE;
                else if (pix_cnt == PIX_LAST) state_nxt = S_DRAIN;
            end
            // Count includes a result arriving this cycle so the frame
            // closes on the same edge that captures the final result.
            S_DRAIN:  if ((res_cnt_nxt == RES_N) || drain_expired) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        grant      = busy ? (gsel ? 2'b10 : 2'b01) : 2'b00;
        src_ready  = (state == S_STREAM) ? grant : 2'b00;
        frame_done = (state == S_DONE);
    end

    // Control registers: FSM, arbitration, counters, error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            gsel         <= 1'b0;
            rr_ptr       <= 1'b0;
            res_src      <= 1'b0;
            clr_cnt      <= '0;
            pix_cnt      <= '0;
            res_cnt      <= '0;
            drain_cnt    <= '0;
            err_underrun <= 1'b0;
            err_count    <= 1'b0;
            eng_rst_n    <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Engine reset follows the next state so it is low exactly while in CLEAR.
            eng_rst_n <= (state_nxt != S_CLEAR);

            if (state == S_IDLE && (|req)) begin
                gsel    <= win_id;
                res_src <= win_id;
                rr_ptr  <= ~win_id;
            end

            clr_cnt   <= (state == S_CLEAR) ? clr_cnt + CLRW'(1) : '0;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + TW'(1) : '0;

            if (state == S_CLEAR) begin
                pix_cnt      <= '0;
                res_cnt      <= '0;
                err_underrun <= 1'b0;
                err_count    <= 1'b0;
            end else begin
                res_cnt <= res_cnt_nxt;
                if (state == S_STREAM) begin
                    if (sel_valid) pix_cnt      <= sat_inc(pix_cnt);
                    else           err_underrun <= 1'b1;
                end
                if (res_extra)
                    err_count <= 1'b1;
                if (state == S_DRAIN && drain_expired && res_cnt_nxt < RES_N)
                    err_count <= 1'b1;
            end
        end
    end

    // Output stage: pixel to engine and result forwarding, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_pic     <= '0;
            eng_pic_vld <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_last    <= 1'b0;
        end else begin
            eng_pic_vld <= (state == S_STREAM) && sel_valid;
            if (state == S_STREAM && sel_valid)
                eng_pic <= sel_pix;
            res_valid <= res_take;
            res_last  <= res_take && (res_cnt == RES_N - 10'd1);
            if (res_take)
                res_data <= eng_out;
        end
    end

endmodule

// File: tb/tb_conv_frame_sched.sv
// tb_conv_frame_sched
//   Directed bench for conv_frame_sched: drives ramp pixel frames from either
//   source, models the engine as a delayed burst of numbered results, and
//   checks grants, engine reset, pixel stream, result forwarding and errors.
module tb_conv_frame_sched;

    localparam int DW       = 16;
    localparam int OW       = 33;
    localparam int IMG_W    = 28;
    localparam int IMG_H    = 28;
    localparam int CLR_CYC  = 2;
    localparam int DRAIN_TO = 16;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int NRES     = (IMG_W - 2) * (IMG_H - 2);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req;
    logic [1:0]           grant;
    logic [2*DW-1:0]      src_data;
    logic [1:0]           src_valid;
    logic [1:0]           src_ready;
    logic                 eng_rst_n;
    logic signed [DW-1:0] eng_pic;
    logic                 eng_pic_vld;
    logic                 eng_out_vld;
    logic signed [OW-1:0] eng_out;
    logic                 res_valid;
    logic signed [OW-1:0] res_data;
    logic                 res_src;
    logic                 res_last;
    logic                 frame_done;
    logic                 err_underrun;
    logic                 err_count;
    logic                 busy;

    conv_frame_sched #(
        .DW(DW), .OW(OW), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .CLR_CYC(CLR_CYC), .DRAIN_TO(DRAIN_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .eng_rst_n(eng_rst_n), .eng_pic(eng_pic), .eng_pic_vld(eng_pic_vld),
        .eng_out_vld(eng_out_vld), .eng_out(eng_out),
        .res_valid(res_valid), .res_data(res_data), .res_src(res_src),
        .res_last(res_last), .frame_done(frame_done),
        .err_underrun(err_underrun), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Per-frame observations
    int   done_cnt, last_cnt, last_idx, res_seen, rstlow, busy_cnt;
    int   cyc_last, cyc_done, pix_idx;
    logic und_d, cnt_d, vld_d, src_d;

    function automatic logic signed [DW-1:0] pix(input int k);
        return DW'(k * 37 - 5000);
    endfunction

    function automatic logic signed [OW-1:0] res_val(input int k);
        longint v;
        v = longint'(k) * 1000 - 123457;
        return OW'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_pix(input int s, input int k);
        if (s == 1) src_data[2*DW-1:DW] = pix(k);
        else        src_data[DW-1:0]    = pix(k);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/grant"},        64'(grant),        64'(0));
        chk({tag, "/src_ready"},    64'(src_ready),    64'(0));
        chk({tag, "/eng_rst_n"},    64'(eng_rst_n),    64'(0));
        chk({tag, "/eng_pic"},      64'(eng_pic),      64'(0));
        chk({tag, "/eng_pic_vld"},  64'(eng_pic_vld),  64'(0));
        chk({tag, "/res_valid"},    64'(res_valid),    64'(0));
        chk({tag, "/res_data"},     64'(res_data),     64'(0));
        chk({tag, "/res_src"},      64'(res_src),      64'(0));
        chk({tag, "/res_last"},     64'(res_last),     64'(0));
        chk({tag, "/frame_done"},   64'(frame_done),   64'(0));
        chk({tag, "/err_underrun"}, 64'(err_underrun), 64'(0));
        chk({tag, "/err_count"},    64'(err_count),    64'(0));
        chk({tag, "/busy"},         64'(busy),         64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    // One frame from source s. drop_at: first pixel index presented invalid
    // (-1 = none). rst_at: assert rst_n once this many pixels are accepted
    // (-1 = none). Engine emits nres results, starting delay cycles after the
    // first pixel reaches it.
    task automatic run_frame(input int s, input int drop_at, input int rst_at,
                             input int nres, input int delay, input bit hold);
        int                   res_emit, wait_cnt, lim;
        bit                   started, acc, stop;
        logic signed [DW-1:0] pic_exp;
        logic [1:0]           gexp;
        done_cnt = 0; last_cnt = 0; last_idx = -1; res_seen = 0; rstlow = 0;
        busy_cnt = 0; cyc_last = -1; cyc_done = -1; pix_idx = 0;
        und_d = 1'bx; cnt_d = 1'bx; vld_d = 1'bx; src_d = 1'bx;
        res_emit = 0; wait_cnt = 0; started = 1'b0; stop = 1'b0;
        gexp = (s == 1) ? 2'b10 : 2'b01;
        lim  = (drop_at >= 0) ? drop_at : NPIX;
        src_valid    = 2'b00;
        src_valid[s] = 1'b1;
        set_pix(s, 0);
        eng_out_vld = 1'b0;
        eng_out     = '0;
        for (int i = 0; i < 3000 && !stop; i++) begin
            acc     = src_ready[s] && src_valid[s];
            pic_exp = pix(pix_idx);
            tick();
            if (acc) begin
                chk("eng_pic", 64'(eng_pic), 64'(pic_exp));
                chk("eng_pic_vld", 64'(eng_pic_vld), 64'(1));
                pix_idx++;
                if (pix_idx == NPIX) cyc_last = cyc;
            end
            if (busy) begin
                busy_cnt++;
                chk("grant_busy", 64'(grant), 64'(gexp));
            end else begin
                chk("grant_idle", 64'(grant), 64'(0));
            end
            if (!eng_rst_n) rstlow++;
            if (res_valid) begin
                chk("res_data", 64'(res_data), 64'(res_val(res_seen)));
                if (res_last) begin
                    last_cnt++;
                    last_idx = res_seen;
                end
                res_seen++;
            end
            if (frame_done) begin
                done_cnt++;
                cyc_done = cyc;
                und_d = err_underrun;
                cnt_d = err_count;
                vld_d = eng_pic_vld;
                src_d = res_src;
                stop  = 1'b1;
            end else begin
                if (busy && !hold) req = 2'b00;
                src_valid[s] = (pix_idx < lim);
                set_pix(s, pix_idx);
                if (!started && eng_pic_vld) begin
                    started  = 1'b1;
                    wait_cnt = delay;
                end
                eng_out_vld = 1'b0;
                if (started) begin
                    if (wait_cnt > 0) begin
                        wait_cnt--;
                    end else if (res_emit < nres) begin
                        eng_out_vld = 1'b1;
                        eng_out     = res_val(res_emit);
                        res_emit++;
                    end
                end
                if (rst_at >= 0 && pix_idx == rst_at) begin
                    rst_n = 1'b0;
                    #2;
                    chk_reset("mid_rst");
                    stop = 1'b1;
                end
            end
        end
        src_valid   = 2'b00;
        eng_out_vld = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_busy, input int exp_last,
                               input logic exp_und, input logic exp_cnt,
                               input logic exp_src, input int exp_res);
        chk({tag, "/frame_done_cnt"}, 64'(done_cnt), 64'(1));
        chk({tag, "/busy_cycles"},    64'(busy_cnt), 64'(exp_busy));
        chk({tag, "/eng_rst_low"},    64'(rstlow),   64'(CLR_CYC));
        chk({tag, "/res_last_cnt"},   64'(last_cnt), 64'(exp_last));
        chk({tag, "/res_count"},      64'(res_seen), 64'(exp_res));
        chk({tag, "/err_underrun"},   64'(und_d),    64'(exp_und));
        chk({tag, "/err_count"},      64'(cnt_d),    64'(exp_cnt));
        chk({tag, "/pic_vld_end"},    64'(vld_d),    64'(0));
        chk({tag, "/res_src"},        64'(src_d),    64'(exp_src));
        if (exp_last == 1)
            chk({tag, "/res_last_idx"}, 64'(last_idx), 64'(NRES - 1));
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = 2'b00;
        src_valid   = 2'b00;
        src_data    = {2{16'h7777}};
        eng_out_vld = 1'b0;
        eng_out     = '0;
        tick();
        tick();
        chk_reset("por");
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("idle/eng_rst_n", 64'(eng_rst_n), 64'(1));
        chk("idle/busy",      64'(busy),      64'(0));

        // 1: single frame from source 0, req dropped mid-frame
        req = 2'b01;
        run_frame(0, -1, -1, NRES, 110, 1'b0);
        check_frame("t1", 790, 1, 1'b0, 1'b0, 1'b0, NRES);
        tick();
        chk("t1/busy_after",  64'(busy),       64'(0));
        chk("t1/done_pulse",  64'(frame_done), 64'(0));

        // 2: both sources requesting for three frames, round-robin from source 0
        do_reset();
        req = 2'b11;
        run_frame(0, -1, -1, NRES, 110, 1'b1);
        check_frame("t2a", 790, 1, 1'b0, 1'b0, 1'b0, NRES);
        run_frame(1, -1, -1, NRES, 110, 1'b1);
        check_frame("t2b", 790, 1, 1'b0, 1'b0, 1'b1, NRES);
        run_frame(0, -1, -1, NRES, 110, 1'b1);
        req = 2'b00;
        check_frame("t2c", 790, 1, 1'b0, 1'b0, 1'b0, NRES);

        // 3: underrun at pixel 300, then a clean frame clears the flag
        req = 2'b01;
        run_frame(0, 300, -1, NRES, 110, 1'b0);
        check_frame("t3", 304, 0, 1'b1, 1'b0, 1'b0, 190);
        chk("t3/pixels", 64'(pix_idx), 64'(300));
        req = 2'b10;
        run_frame(1, -1, -1, NRES, 110, 1'b0);
        check_frame("t3b", 790, 1, 1'b0, 1'b0, 1'b1, NRES);

        // 4: engine short by 76 results, drain times out
        req = 2'b01;
        run_frame(0, -1, -1, 600, 110, 1'b0);
        check_frame("t4", 803, 0, 1'b0, 1'b1, 1'b0, 600);
        chk("t4/drain_cycles", 64'(cyc_done - cyc_last), 64'(DRAIN_TO));

        // 5: engine emits 4 surplus results
        req = 2'b10;
        run_frame(1, -1, -1, 680, 50, 1'b0);
        check_frame("t5", 788, 1, 1'b0, 1'b1, 1'b1, NRES);
        chk("t5/drain_cycles", 64'(cyc_done - cyc_last), 64'(1));

        // 6: asynchronous reset at pixel 400, then a fresh frame
        req = 2'b10;
        run_frame(1, -1, 400, NRES, 110, 1'b0);
        req = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        req = 2'b01;
        run_frame(0, -1, -1, NRES, 110, 1'b0);
        check_frame("t6", 790, 1, 1'b0, 1'b0, 1'b0, NRES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
